// File: rtl/bus_arbiter_rr_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_rr_if
//
// Handshake bundle between two bus masters and the round-robin arbiter.
//
// Signals:
//   m1_breq   - bus request from master 1
//   m2_breq   - bus request from master 2
//   m1_bgrant - bus grant to master 1
//   m2_bgrant - bus grant to master 2
//   msel      - bus mux select, 0 = master 1, 1 = master 2
//   bus_busy  - high while either grant is active
//   timeout   - current holder kept the bus too long while the other waits
//
// Modports:
//   master  - request side (drives requests, observes grants and status)
//   slave   - arbiter side (observes requests, drives grants and status)
//   monitor - passive observer of every signal
// ----------------------------------------------------------------------------
interface bus_arbiter_rr_if;

  logic m1_breq;
  logic m2_breq;
  logic m1_bgrant;
  logic m2_bgrant;
  logic msel;
  logic bus_busy;
  logic timeout;

  modport master (
    output m1_breq,
    output m2_breq,
    input  m1_bgrant,
    input  m2_bgrant,
    input  msel,
    input  bus_busy,
    input  timeout
  );

  modport slave (
    input  m1_breq,
    input  m2_breq,
    output m1_bgrant,
    output m2_bgrant,
    output msel,
    output bus_busy,
    output timeout
  );

  modport monitor (
    input m1_breq,
    input m2_breq,
    input m1_bgrant,
    input m2_bgrant,
    input msel,
    input bus_busy,
    input timeout
  );

endinterface

// File: rtl/bus_arbiter_rr.sv
// ----------------------------------------------------------------------------
// bus_arbiter_rr
//
// Two-master bus arbiter with round-robin tie breaking, a mandatory one-cycle
// IDLE turnaround between owners and a hold-time watchdog flag.
//
// Parameters:
//   MAX_HOLD - grant-hold cycle count at which timeout may assert (1..65534)
//
// Ports:
//   clk  - single clock, rising edge
//   rstn - synchronous active-low reset
//   bus  - bus_arbiter_rr_if.slave: requests in; grants, msel, bus_busy and
//          timeout out (all outputs registered)
//
// Behaviour summary:
//   - IDLE grants a single requester one edge after sampling its request;
//     with both requesting, the master that was not served last wins.
//   - A grant is held for as long as the owner keeps its request high; the
//     arbiter never revokes it. Dropping the request returns to IDLE.
//   - hold_cnt counts cycles in the current grant (saturating). timeout is a
//     sticky status flag for the current grant only; it never affects grants.
// ----------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int unsigned MAX_HOLD = 1023
) (
  input  logic              clk,
  input  logic              rstn,
  bus_arbiter_rr_if.slave   bus
);

  localparam logic [15:0] MaxHold = 16'(MAX_HOLD);
  localparam logic [15:0] CntMax  = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt1 = 2'b01,
    StGnt2 = 2'b10
  } state_e;

  state_e      state;
  // 0 = master 1 served last, 1 = master 2 served last.
  logic        last_served;
  logic [15:0] hold_cnt;

  logic        m1_bgrant;
  logic        m2_bgrant;
  logic        msel;
  logic        bus_busy;
  logic        timeout;

  // Counter value the grant state will hold after this edge if it is kept.
  logic [15:0] hold_cnt_inc;
  assign hold_cnt_inc = (hold_cnt == CntMax) ? hold_cnt : hold_cnt + 16'd1;

  // Single-process FSM. Outputs are computed from the next state so that they
  // are registered yet line up with the state register on every edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= StIdle;
      last_served <= 1'b1;  // master 2, so master 1 wins the first tie
      hold_cnt    <= 16'd0;
      m1_bgrant   <= 1'b0;
      m2_bgrant   <= 1'b0;
      msel        <= 1'b0;
      bus_busy    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.m1_breq && (!bus.m2_breq || last_served)) begin
            state     <= StGnt1;
            hold_cnt  <= 16'd0;
            m1_bgrant <= 1'b1;
            m2_bgrant <= 1'b0;
            msel      <= 1'b0;
            bus_busy  <= 1'b1;
            timeout   <= 1'b0;
          end else if (bus.m2_breq) begin
            state     <= StGnt2;
            hold_cnt  <= 16'd0;
            m1_bgrant <= 1'b0;
            m2_bgrant <= 1'b1;
            msel      <= 1'b1;
            bus_busy  <= 1'b1;
            timeout   <= 1'b0;
          end else begin
            // msel keeps its last value through IDLE.
            m1_bgrant <= 1'b0;
            m2_bgrant <= 1'b0;
            bus_busy  <= 1'b0;
            timeout   <= 1'b0;
          end
        end

        StGnt1: begin
          if (bus.m1_breq) begin
            hold_cnt <= hold_cnt_inc;
            // Sticky for the rest of this grant once the other master waited
            // past the limit.
            if ((hold_cnt_inc >= MaxHold) && bus.m2_breq) begin
              timeout <= 1'b1;
            end
          end else begin
            state       <= StIdle;
            last_served <= 1'b0;
            m1_bgrant   <= 1'b0;
            bus_busy    <= 1'b0;
            timeout     <= 1'b0;
          end
        end

        StGnt2: begin
          if (bus.m2_breq) begin
            hold_cnt <= hold_cnt_inc;
            if ((hold_cnt_inc >= MaxHold) && bus.m1_breq) begin
              timeout <= 1'b1;
            end
          end else begin
            state       <= StIdle;
            last_served <= 1'b1;
            m2_bgrant   <= 1'b0;
            bus_busy    <= 1'b0;
            timeout     <= 1'b0;
          end
        end

        default: begin
          state     <= StIdle;
          m1_bgrant <= 1'b0;
          m2_bgrant <= 1'b0;
          bus_busy  <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m1_bgrant = m1_bgrant;
  assign bus.m2_bgrant = m2_bgrant;
  assign bus.msel      = msel;
  assign bus.bus_busy  = bus_busy;
  assign bus.timeout   = timeout;

  // Structural invariants of the arbiter.
  grant_onehot_a : assert property (@(posedge clk) !(m1_bgrant && m2_bgrant));

  // Ownership always changes through IDLE.
  no_direct_handover_a : assert property (@(posedge clk) disable iff (!rstn)
    (state == StGnt1) |=> (state != StGnt2));
  no_direct_handover2_a : assert property (@(posedge clk) disable iff (!rstn)
    (state == StGnt2) |=> (state != StGnt1));

  busy_matches_grants_a : assert property (@(posedge clk)
    bus_busy == (m1_bgrant || m2_bgrant));

  timeout_only_in_grant_a : assert property (@(posedge clk)
    timeout |-> bus_busy);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//
// Self-checking bench for bus_arbiter_rr (MAX_HOLD = 8). Directed scenarios
// for the key arbitration cases, followed by randomized request traffic with
// occasional resets. Every cycle is compared against a cycle-level ownership
// model built from integers (owner number, last served, hold count).
// ----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  localparam int MaxHold = 8;

  logic clk;
  logic rstn;

  bus_arbiter_rr_if bus ();

  bus_arbiter_rr #(
    .MAX_HOLD (MaxHold)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner 0 = none, 1 = master 1, 2 = master 2.
  int m_owner = 0;
  int m_last  = 2;
  int m_cnt   = 0;
  int m_msel  = 0;
  int m_to    = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge given the inputs sampled there.
  task automatic model_step(input bit r1, input bit r2, input bit rn);
    int rq [3];
    rq[0] = 0;
    rq[1] = int'(r1);
    rq[2] = int'(r2);
    if (!rn) begin
      m_owner = 0;
      m_last  = 2;
      m_cnt   = 0;
      m_msel  = 0;
      m_to    = 0;
    end else if (m_owner == 0) begin
      if (r1 && r2)  m_owner = (m_last == 1) ? 2 : 1;
      else if (r1)   m_owner = 1;
      else if (r2)   m_owner = 2;
      if (m_owner != 0) begin
        m_msel = m_owner - 1;
        m_cnt  = 0;
        m_to   = 0;
      end
    end else if (rq[m_owner] != 0) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_cnt >= MaxHold && rq[3 - m_owner] != 0) m_to = 1;
    end else begin
      m_last  = m_owner;
      m_owner = 0;
      m_to    = 0;
    end
  endtask

  task automatic check_model();
    check_eq("m1_bgrant", int'(bus.m1_bgrant), int'(m_owner == 1));
    check_eq("m2_bgrant", int'(bus.m2_bgrant), int'(m_owner == 2));
    check_eq("msel",      int'(bus.msel),      m_msel);
    check_eq("bus_busy",  int'(bus.bus_busy),  int'(m_owner != 0));
    check_eq("timeout",   int'(bus.timeout),   m_to);
  endtask

  // Apply inputs, take one edge, then compare 1 time unit after it.
  task automatic step(input bit r1, input bit r2, input bit rn);
    bus.m1_breq = r1;
    bus.m2_breq = r2;
    rstn        = rn;
    @(posedge clk);
    model_step(r1, r2, rn);
    #1;
    check_model();
  endtask

  bit rr1;
  bit rr2;
  bit rrn;

  initial begin
    bus.m1_breq = 1'b0;
    bus.m2_breq = 1'b0;
    rstn        = 1'b0;

    // Reset state.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    check_eq("rst_busy", int'(bus.bus_busy), 0);
    check_eq("rst_msel", int'(bus.msel), 0);

    // Tie right after reset: master 1 wins.
    step(1'b1, 1'b1, 1'b1);
    check_eq("tie_m1", int'(bus.m1_bgrant), 1);
    check_eq("tie_m2", int'(bus.m2_bgrant), 0);
    check_eq("tie_msel", int'(bus.msel), 0);

    // Master 1 holds 5 cycles total, drops with m2 waiting.
    repeat (4) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check_eq("turn_m1", int'(bus.m1_bgrant), 0);
    check_eq("turn_m2", int'(bus.m2_bgrant), 0);
    check_eq("turn_msel_held", int'(bus.msel), 0);
    step(1'b0, 1'b1, 1'b1);
    check_eq("hand_m2", int'(bus.m2_bgrant), 1);
    check_eq("hand_msel", int'(bus.msel), 1);

    // Reset during GNT2 drops the grant on that edge; then m1 alone.
    step(1'b1, 1'b1, 1'b0);
    check_eq("midrst_m2", int'(bus.m2_bgrant), 0);
    check_eq("midrst_msel", int'(bus.msel), 0);
    step(1'b1, 1'b0, 1'b1);
    check_eq("postrst_m1", int'(bus.m1_bgrant), 1);

    // One-cycle m2 pulse while m1 holds is forgotten.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_eq("pulse_m2", int'(bus.m2_bgrant), 0);
    check_eq("pulse_busy", int'(bus.bus_busy), 0);

    // Timeout: m1 holds 20 cycles with m2 waiting (last served is m1, so
    // present m1 alone to win).
    step(1'b1, 1'b0, 1'b1);
    check_eq("to_enter", int'(bus.m1_bgrant), 1);
    for (int k = 1; k <= 19; k++) begin
      step(1'b1, 1'b1, 1'b1);
      check_eq("to_hold", int'(bus.timeout), int'(k >= MaxHold));
    end
    step(1'b0, 1'b1, 1'b1);
    check_eq("to_clear", int'(bus.timeout), 0);
    check_eq("to_rel_m1", int'(bus.m1_bgrant), 0);
    step(1'b0, 1'b1, 1'b1);
    check_eq("to_next_m2", int'(bus.m2_bgrant), 1);
    check_eq("to_next_to", int'(bus.timeout), 0);

    // Alternating contention from reset, 3-cycle holds.
    step(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      step(1'b1, 1'b1, 1'b1);
      check_eq("alt_m1", int'(bus.m1_bgrant), int'(r % 2 == 0));
      check_eq("alt_m2", int'(bus.m2_bgrant), int'(r % 2 == 1));
      repeat (2) step(1'b1, 1'b1, 1'b1);
      if (r % 2 == 0) step(1'b0, 1'b1, 1'b1);
      else            step(1'b1, 1'b0, 1'b1);
      check_eq("alt_idle", int'(bus.bus_busy), 0);
    end

    // Randomized traffic with sticky requests and rare resets.
    rr1 = 1'b0;
    rr2 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) rr1 = ~rr1;
      if ($urandom_range(15) == 0) rr2 = ~rr2;
      rrn = ($urandom_range(299) != 0);
      step(rr1, rr2, rrn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 1023, giving the grant-hold cycle count after which timeout is flagged (legal range 1..65534).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port m1_breq, input, 1, bus request from master 1.
REQ-005 The block SHALL have port m2_breq, input, 1, bus request from master 2.
REQ-006 The block SHALL have port m1_bgrant, output, 1, bus grant to master 1.
REQ-007 The block SHALL have port m2_bgrant, output, 1, bus grant to master 2.
REQ-008 The block SHALL have port msel, output, 1, bus mux select: 0 = master 1, 1 = master 2.
REQ-009 The block SHALL have port bus_busy, output, 1, high while any grant is active.
REQ-010 The block SHALL have port timeout, output, 1, high when the holder has exceeded MAX_HOLD while the other master waits.

Function
REQ-011 The block SHALL implement FSM states IDLE, GNT1, GNT2, plus a 1-bit last_served register and a 16-bit hold counter hold_cnt.
REQ-012 All outputs SHALL be registered; m1_bgrant = (state==GNT1), m2_bgrant = (state==GNT2), bus_busy = (state!=IDLE).
REQ-013 In IDLE, with only m1_breq high, the block SHALL enter GNT1; with only m2_breq high, GNT2; with neither, remain IDLE.
REQ-014 In IDLE, with both requests high, the block SHALL grant the master not equal to last_served (round-robin).
REQ-015 Grant latency SHALL be exactly one cycle: request sampled high at edge n in IDLE -> grant high after edge n+1.
REQ-016 In GNT1 (GNT2), the block SHALL stay while m1_breq (m2_breq) is high; the grant is never revoked by the arbiter.
REQ-017 When the holder drops its breq, the block SHALL return to IDLE for at least one turnaround cycle with both grants low, and set last_served to that master.
REQ-018 No direct GNT1<->GNT2 transition SHALL exist; both grants SHALL never be high simultaneously.
REQ-019 msel SHALL update on entry to GNT1/GNT2 and SHALL hold its last value through IDLE.
REQ-020 hold_cnt SHALL clear to 0 on entry to a grant state, increment by 1 each cycle in that state, and saturate at 65535.
REQ-021 timeout SHALL assert when in a grant state with hold_cnt >= MAX_HOLD and the other master's breq high; once set it SHALL stay high until the state leaves the grant state.
REQ-022 timeout SHALL be a status flag only and SHALL NOT alter grant or FSM behaviour.
REQ-023 A request that drops while in IDLE before the grant SHALL be ignored on the next evaluation; no grant is issued for a deasserted request.

Reset
REQ-024 With rstn low at a clock edge, the block SHALL enter IDLE, drive m1_bgrant=0, m2_bgrant=0, msel=0, bus_busy=0, timeout=0, hold_cnt=0, and last_served=master 2 so master 1 wins the first tie.
REQ-025 Reset asserted mid-grant SHALL drop the grant on the same edge with no turnaround, and the block SHALL ignore requests while rstn is low.

Verification
REQ-026 Reset release, both breq high at the same cycle -> m1_bgrant=1 and msel=0 one cycle later, m2_bgrant=0.
REQ-027 Master 1 holds 5 cycles, then drops while m2_breq stays high -> 1 IDLE cycle with both grants 0, then m2_bgrant=1 and msel=1.
REQ-028 Alternating contention, both breq always high with each holder dropping after 3 cycles -> grants alternate M1, M2, M1, M2 and never overlap.
REQ-029 MAX_HOLD=8, master 1 holds 20 cycles with m2_breq high -> timeout rises once hold_cnt reaches 8, stays 1 until m1 releases, then falls with the grant.
REQ-030 rstn pulsed low during GNT2 -> grants 0 and msel=0 on that edge; after release with only m1_breq high -> GNT1 is entered.
REQ-031 m2_breq pulsed high for one cycle while GNT1 is held -> no m2 grant after m1 releases if m2_breq is low at evaluation.
